// File: rtl/spi_flash_reader_pkg.sv
// ---------------------------------------------------------------------------
// spi_flash_reader_pkg
// Shared constants and types for the SPI NOR boot/ROM fetch engine:
//   OPC_WAKE / OPC_READ : default flash opcodes (release deep power-down, READ)
//   WORD_BITS / ADDR_BITS: fetched word width and word-address width
//   state_t             : top-level sequencer state encoding
//   f_byte_addr         : word address -> 24-bit flash byte address
// ---------------------------------------------------------------------------
package spi_flash_reader_pkg;

   localparam logic [7:0] OPC_WAKE  = 8'hAB;
   localparam logic [7:0] OPC_READ  = 8'h03;
   localparam int         WORD_BITS = 32;
   localparam int         ADDR_BITS = 22;

   typedef enum logic [2:0] {
      ST_WAKE      = 3'd0,
      ST_WAKE_WAIT = 3'd1,
      ST_IDLE      = 3'd2,
      ST_CMD       = 3'd3,
      ST_DATA      = 3'd4,
      ST_ACK       = 3'd5,
      ST_OPEN      = 3'd6,
      ST_CSH       = 3'd7
   } state_t;

   // Words are 4 bytes, so the flash byte address is the word address times 4.
   function automatic logic [23:0] f_byte_addr(input logic [ADDR_BITS-1:0] i_word_addr);
      return {i_word_addr, 2'b00};
   endfunction

endpackage

// File: rtl/spi_flash_reader_if.sv
// ---------------------------------------------------------------------------
// spi_flash_reader_if
// ROM fetch handshake between the bus FSM (master) and the flash reader (slave).
//   rom_stb   : one-cycle request pulse            (master -> slave)
//   rom_addr  : 22-bit word address                (master -> slave)
//   rom_ack   : one-cycle pulse, rom_odata valid   (slave -> master)
//   rom_odata : fetched 32-bit word, held to next ack (slave -> master)
// ---------------------------------------------------------------------------
interface spi_flash_reader_if;
   import spi_flash_reader_pkg::*;

   logic                 rom_stb;
   logic [ADDR_BITS-1:0] rom_addr;
   logic                 rom_ack;
   logic [WORD_BITS-1:0] rom_odata;

   modport master (output rom_stb, output rom_addr, input rom_ack, input rom_odata);
   modport slave  (input rom_stb, input rom_addr, output rom_ack, output rom_odata);

endinterface

// File: rtl/spi_flash_reader_spi_bit_shifter.sv
// ---------------------------------------------------------------------------
// spi_bit_shifter
// Mode-0 SPI bit engine. Each bit is two clk: phase A (sck=0, mosi holds the
// bit, MSB first) then phase B (sck=1). miso is sampled on the edge that ends
// phase B. Ports:
//   clk, rst   : clock, async active-low reset
//   i_load     : start a transfer of i_nbits bits (1..32) taken from i_data MSB
//   i_nbits    : number of bits to shift
//   i_data     : outgoing bits, MSB-aligned
//   i_miso     : serial input from the flash
//   o_sck      : SPI clock (registered)
//   o_mosi     : serial output (registered)
//   o_busy     : transfer in progress
//   o_last     : high on the clk edge that completes the final bit
//   o_word     : received word including the bit sampled on the o_last edge
// ---------------------------------------------------------------------------
module spi_bit_shifter
   import spi_flash_reader_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_load,
   input  logic [5:0]           i_nbits,
   input  logic [WORD_BITS-1:0] i_data,
   input  logic                 i_miso,
   output logic                 o_sck,
   output logic                 o_mosi,
   output logic                 o_busy,
   output logic                 o_last,
   output logic [WORD_BITS-1:0] o_word
);

   logic                 r_busy;
   logic                 r_phase;
   logic [5:0]           r_cnt;
   logic [WORD_BITS-2:0] r_sh;   // bits still to send after the one on mosi
   logic [WORD_BITS-2:0] r_rx;   // bits received so far
   logic                 r_sck;
   logic                 r_mosi;

   // The final bit's closing edge: lets the sequencer chain the next load
   // on the same edge so no idle clk appears between fields.
   assign o_last = r_busy & r_phase & (r_cnt == 6'd1);
   assign o_word = {r_rx, i_miso};
   assign o_busy = r_busy;
   assign o_sck  = r_sck;
   assign o_mosi = r_mosi;

   // Bit phase sequencing, shift registers and registered SPI pins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy  <= 1'b0;
         r_phase <= 1'b0;
         r_cnt   <= 6'd0;
         r_sh    <= {(WORD_BITS-1){1'b0}};
         r_rx    <= {(WORD_BITS-1){1'b0}};
         r_sck   <= 1'b0;
         r_mosi  <= 1'b0;
      end else if (i_load) begin
         r_busy  <= 1'b1;
         r_phase <= 1'b0;
         r_cnt   <= i_nbits;
         r_sh    <= i_data[WORD_BITS-2:0];
         r_sck   <= 1'b0;
         r_mosi  <= i_data[WORD_BITS-1];
      end else if (r_busy) begin
         if (!r_phase) begin
            r_phase <= 1'b1;
            r_sck   <= 1'b1;
         end else begin
            r_phase <= 1'b0;
            r_sck   <= 1'b0;
            r_rx    <= {r_rx[WORD_BITS-3:0], i_miso};
            r_sh    <= {r_sh[WORD_BITS-3:0], 1'b0};
            r_cnt   <= r_cnt - 6'd1;
            if (r_cnt == 6'd1) begin
               r_busy <= 1'b0;
               r_mosi <= 1'b0;
            end else begin
               r_mosi <= r_sh[WORD_BITS-2];
            end
         end
      end else begin
         r_sck <= 1'b0;
      end
   end

endmodule

// File: rtl/spi_flash_reader.sv
// ---------------------------------------------------------------------------
// spi_flash_reader
// Boot/ROM fetch engine: reads 32-bit big-endian words from SPI NOR flash with
// READ (0x03), wakes the flash from deep power-down after reset, and keeps the
// READ burst open so a request for last_addr+1 costs only the data phase.
// Ports:
//   clk, rst     : clock, async active-low reset
//   bus          : ROM handshake (slave modport of spi_flash_reader_if)
//   o_spi_ss     : chip select, active low
//   o_spi_sck    : SPI clock, mode 0, clk/2
//   o_spi_mosi   : serial out to flash
//   i_spi_miso   : serial in from flash
//   o_spi_io2/3  : WP# / HOLD#, held high
// ---------------------------------------------------------------------------
module spi_flash_reader
   import spi_flash_reader_pkg::*;
#(
   parameter logic [7:0] WAKE_CMD    = OPC_WAKE,
   parameter logic [7:0] READ_CMD    = OPC_READ,
   parameter int         WAKE_CYCLES = 600,
   parameter int         CSH_CYCLES  = 4,
   parameter bit         SEQ_EN      = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_flash_reader_if.slave     bus,
   output logic                  o_spi_ss,
   output logic                  o_spi_sck,
   output logic                  o_spi_mosi,
   input  logic                  i_spi_miso,
   output logic                  o_spi_io2,
   output logic                  o_spi_io3
);

   localparam int CNT_MAX = (WAKE_CYCLES > CSH_CYCLES) ? WAKE_CYCLES : CSH_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_ss;
   logic                 r_ack;
   logic [WORD_BITS-1:0] r_odata;
   logic [CNT_W-1:0]     r_cnt;
   logic [ADDR_BITS-1:0] r_addr;
   logic [ADDR_BITS-1:0] r_last_addr;
   logic                 r_pend;

   logic                 w_load;
   logic [5:0]           w_nbits;
   logic [WORD_BITS-1:0] w_ld_data;
   logic                 w_ss_nxt;
   logic                 w_ack_nxt;
   logic                 w_odata_en;
   logic                 w_cnt_clr;
   logic                 w_cnt_inc;
   logic                 w_addr_ld;
   logic                 w_pend_set;
   logic                 w_pend_clr;
   logic                 w_last_ld;
   logic [ADDR_BITS-1:0] w_req_addr;
   logic                 w_busy;
   logic                 w_last;
   logic [WORD_BITS-1:0] w_word;

   // A request captured during wake-up or while leaving an open burst wins over the live bus.
   assign w_req_addr = r_pend ? r_addr : bus.rom_addr;

   spi_bit_shifter u_shifter (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_nbits (w_nbits),
      .i_data  (w_ld_data),
      .i_miso  (i_spi_miso),
      .o_sck   (o_spi_sck),
      .o_mosi  (o_spi_mosi),
      .o_busy  (w_busy),
      .o_last  (w_last),
      .o_word  (w_word)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_WAKE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and per-state control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_nbits     = 6'd32;
      w_ld_data   = {WORD_BITS{1'b0}};
      w_ss_nxt    = r_ss;
      w_ack_nxt   = 1'b0;
      w_odata_en  = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_inc   = 1'b0;
      w_addr_ld   = 1'b0;
      w_pend_set  = 1'b0;
      w_pend_clr  = 1'b0;
      w_last_ld   = 1'b0;
      case (r_state)
         ST_WAKE: begin
            if (bus.rom_stb) begin
               w_addr_ld  = 1'b1;
               w_pend_set = 1'b1;
            end else begin
               w_addr_ld  = 1'b0;
            end
            if (w_last) begin
               w_ss_nxt    = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = ST_WAKE_WAIT;
            end else if (!w_busy) begin
               // First cycle out of reset: shifter idle, start the wake opcode.
               w_load    = 1'b1;
               w_nbits   = 6'd8;
               w_ld_data = {WAKE_CMD, 24'h000000};
               w_ss_nxt  = 1'b0;
            end else begin
               w_load = 1'b0;
            end
         end
         ST_WAKE_WAIT: begin
            if (bus.rom_stb) begin
               w_addr_ld  = 1'b1;
               w_pend_set = 1'b1;
            end else begin
               w_addr_ld  = 1'b0;
            end
            if (r_cnt == CNT_W'(WAKE_CYCLES - 1)) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         ST_IDLE: begin
            if (bus.rom_stb || r_pend) begin
               w_addr_ld   = ~r_pend;
               w_pend_clr  = 1'b1;
               w_load      = 1'b1;
               w_ld_data   = {READ_CMD, f_byte_addr(w_req_addr)};
               w_ss_nxt    = 1'b0;
               w_state_nxt = ST_CMD;
            end else begin
               w_ss_nxt = 1'b1;
            end
         end
         ST_CMD: begin
            if (w_last) begin
               w_load      = 1'b1;
               w_state_nxt = ST_DATA;
            end else begin
               w_load = 1'b0;
            end
         end
         ST_DATA: begin
            if (w_last) begin
               w_ack_nxt   = 1'b1;
               w_odata_en  = 1'b1;
               w_last_ld   = 1'b1;
               w_state_nxt = ST_ACK;
            end else begin
               w_ack_nxt = 1'b0;
            end
         end
         ST_ACK: begin
            if (SEQ_EN) begin
               w_state_nxt = ST_OPEN;
            end else begin
               w_ss_nxt    = 1'b1;
               w_cnt_clr   = 1'b1;
               w_state_nxt = ST_CSH;
            end
         end
         ST_OPEN: begin
            // The flash auto-increments its 24-bit address, and so does the
            // 22-bit compare, so wrap-around still counts as sequential.
            if (bus.rom_stb) begin
               w_addr_ld = 1'b1;
               if (bus.rom_addr == r_last_addr + 22'd1) begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_DATA;
               end else begin
                  w_pend_set  = 1'b1;
                  w_ss_nxt    = 1'b1;
                  w_cnt_clr   = 1'b1;
                  w_state_nxt = ST_CSH;
               end
            end else begin
               w_addr_ld = 1'b0;
            end
         end
         ST_CSH: begin
            if (r_cnt == CNT_W'(CSH_CYCLES - 1)) begin
               if (r_pend) begin
                  w_pend_clr  = 1'b1;
                  w_load      = 1'b1;
                  w_ld_data   = {READ_CMD, f_byte_addr(r_addr)};
                  w_ss_nxt    = 1'b0;
                  w_state_nxt = ST_CMD;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         default: begin
            w_ss_nxt    = 1'b1;
            w_state_nxt = ST_WAKE;
         end
      endcase
   end

   // Registered outputs, wait counter and burst/request bookkeeping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ss        <= 1'b1;
         r_ack       <= 1'b0;
         r_odata     <= {WORD_BITS{1'b0}};
         r_cnt       <= {CNT_W{1'b0}};
         r_addr      <= {ADDR_BITS{1'b0}};
         r_last_addr <= {ADDR_BITS{1'b0}};
         r_pend      <= 1'b0;
      end else begin
         r_ss  <= w_ss_nxt;
         r_ack <= w_ack_nxt;
         if (w_odata_en) begin
            r_odata <= w_word;
         end else begin
            r_odata <= r_odata;
         end
         if (w_cnt_clr) begin
            r_cnt <= {CNT_W{1'b0}};
         end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= r_cnt;
         end
         if (w_addr_ld) begin
            r_addr <= bus.rom_addr;
         end else begin
            r_addr <= r_addr;
         end
         if (w_last_ld) begin
            r_last_addr <= r_addr;
         end else begin
            r_last_addr <= r_last_addr;
         end
         if (w_pend_set) begin
            r_pend <= 1'b1;
         end else if (w_pend_clr) begin
            r_pend <= 1'b0;
         end else begin
            r_pend <= r_pend;
         end
      end
   end

   assign bus.rom_ack   = r_ack;
   assign bus.rom_odata = r_odata;
   assign o_spi_ss      = r_ss;
   assign o_spi_io2     = 1'b1;
   assign o_spi_io3     = 1'b1;

endmodule
